hit_record_filter: RTL and testbench

HIT_RECORD_FILTER -- requirements
Module: hit_record_filter

---
 rtl/hit_record_filter.sv | 154 +++++++++++++++
 tb/tb_hit_record_filter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hit_record_filter.sv
// ETROC2 frame parser: tracks header/data/trailer framing, forwards (optionally
// pixel-filtered) hit records and keeps saturating frame/hit/error statistics.
module hit_record_filter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dinValid,
  input  logic [39:0]      din,
  input  logic             filterEn,
  input  logic [7:0]       selPixel,
  output logic             hitValid,
  output logic [38:0]      hitRecord,
  output logic             frameDone,
  output logic [7:0]       frameL1C,
  output logic [11:0]      frameBCID,
  output logic             frameErr,
  output logic [CNT_W-1:0] frameCnt,
  output logic [CNT_W-1:0] hitCnt,
  output logic [CNT_W-1:0] errCnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             rst_meta_q, rst_hold_q;
  logic [8:0]       fhits_q, fhits_d;
  logic [7:0]       l1c_q, l1c_d;
  logic [11:0]      bcid_q, bcid_d;
  logic             hv_q, hv_d;
  logic [38:0]      rec_q, rec_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       fl1c_q, fl1c_d;
  logic [11:0]      fbcid_q, fbcid_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  logic is_data, is_hdr, is_trl, pix_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  assign is_data = din[39];
  assign is_hdr  = (din[39:38] == 2'b00) && (din[37:22] == 16'h3C5C);
  assign is_trl  = (din[39:38] == 2'b01);
  assign pix_ok  = !filterEn || (din[36:29] == selPixel);

  always_comb begin
    state_d = state_q;
    fhits_d = fhits_q;
    l1c_d   = l1c_q;
    bcid_d  = bcid_q;
    hv_d    = 1'b0;
    rec_d   = rec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fl1c_d  = fl1c_q;
    fbcid_d = fbcid_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    // Words arriving while the synchronised reset is still held are ignored.
    if (dinValid && !rst_hold_q) begin
      if (is_data) begin
        if (state_q == IDLE) begin
          err_d = 1'b1;
        end else begin
          if (fhits_q != 9'd256) fhits_d = fhits_q + 9'd1;
          if (pix_ok) begin
            hv_d   = 1'b1;
            rec_d  = din[38:0];
            hcnt_d = sat_inc(hcnt_q);
          end
        end
      end else if (is_hdr) begin
        if (state_q == FRAME) err_d = 1'b1;
        state_d = FRAME;
        l1c_d   = din[19:12];
        bcid_d  = din[11:0];
        fhits_d = '0;
      end else if (is_trl) begin
        if (state_q == IDLE) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
          // Zero-extended compare also rejects a saturated (256) hit count.
          if (fhits_q == {1'b0, din[16:9]}) begin
            done_d  = 1'b1;
            fl1c_d  = l1c_q;
            fbcid_d = bcid_q;
            fcnt_d  = sat_inc(fcnt_q);
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
    if (err_d) ecnt_d = sat_inc(ecnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_hold_q <= 1'b1;
      state_q    <= IDLE;
      fhits_q    <= '0;
      l1c_q      <= '0;
      bcid_q     <= '0;
      hv_q       <= 1'b0;
      rec_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fl1c_q     <= '0;
      fbcid_q    <= '0;
      fcnt_q     <= '0;
      hcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      rst_meta_q <= 1'b0;
      rst_hold_q <= rst_meta_q;
      state_q    <= state_d;
      fhits_q    <= fhits_d;
      l1c_q      <= l1c_d;
      bcid_q     <= bcid_d;
      hv_q       <= hv_d;
      rec_q      <= rec_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fl1c_q     <= fl1c_d;
      fbcid_q    <= fbcid_d;
      fcnt_q     <= fcnt_d;
      hcnt_q     <= hcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign hitValid  = hv_q;
  assign hitRecord = rec_q;
  assign frameDone = done_q;
  assign frameErr  = err_q;
  assign frameL1C  = fl1c_q;
  assign frameBCID = fbcid_q;
  assign frameCnt  = fcnt_q;
  assign hitCnt    = hcnt_q;
  assign errCnt    = ecnt_q;

endmodule

// File: tb/tb_hit_record_filter.sv
// Directed table-driven bench for hit_record_filter (CNT_W=16 and CNT_W=4 instances).
module tb_hit_record_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dinValid = 1'b0;
  logic [39:0] din = '0;
  logic        filterEn = 1'b0;
  logic [7:0]  selPixel = '0;

  logic        hitValid, frameDone, frameErr;
  logic [38:0] hitRecord;
  logic [7:0]  frameL1C;
  logic [11:0] frameBCID;
  logic [15:0] frameCnt, hitCnt, errCnt;

  logic        hv4, done4, err4;
  logic [38:0] rec4;
  logic [7:0]  l1c4;
  logic [11:0] bcid4;
  logic [3:0]  fcnt4, hcnt4, ecnt4;

  int errors = 0;
  int checks = 0;

  always #12.5 clk = ~clk;

  hit_record_filter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dinValid(dinValid), .din(din),
    .filterEn(filterEn), .selPixel(selPixel),
    .hitValid(hitValid), .hitRecord(hitRecord), .frameDone(frameDone),
    .frameL1C(frameL1C), .frameBCID(frameBCID), .frameErr(frameErr),
    .frameCnt(frameCnt), .hitCnt(hitCnt), .errCnt(errCnt)
  );

  hit_record_filter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .dinValid(dinValid), .din(din),
    .filterEn(filterEn), .selPixel(selPixel),
    .hitValid(hv4), .hitRecord(rec4), .frameDone(done4),
    .frameL1C(l1c4), .frameBCID(bcid4), .frameErr(err4),
    .frameCnt(fcnt4), .hitCnt(hcnt4), .errCnt(ecnt4)
  );

  typedef struct {
    logic        v;
    logic [39:0] din;
    logic        fen;
    logic [7:0]  sel;
    logic        hv;
    logic [38:0] rec;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  logic [38:0] last_rec = '0;

  function automatic logic [39:0] hdr(input logic [7:0] l1c, input logic [11:0] bcid);
    return {2'b00, 16'h3C5C, 2'b00, l1c, bcid};
  endfunction

  function automatic logic [39:0] dw(input logic [7:0] pix, input logic [9:0] tag);
    return {1'b1, 2'b10, pix, tag, tag[8:0], ~tag};
  endfunction

  function automatic logic [39:0] trl(input logic [7:0] n);
    return {2'b01, 21'h0, n, 9'h0};
  endfunction

  // Expected hitRecord follows the last forwarded data word.
  function automatic void add(input logic v, input logic [39:0] w, input logic fen,
                              input logic [7:0] sel, input logic hv,
                              input logic done, input logic err);
    if (hv) last_rec = w[38:0];
    tbl.push_back('{v, w, fen, sel, hv, last_rec, done, err});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      dinValid = tbl[i].v;
      din      = tbl[i].din;
      filterEn = tbl[i].fen;
      selPixel = tbl[i].sel;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].hitValid", tag, i), 64'(hitValid), 64'(tbl[i].hv));
      chk($sformatf("%s[%0d].hitRecord", tag, i), 64'(hitRecord), 64'(tbl[i].rec));
      chk($sformatf("%s[%0d].frameDone", tag, i), 64'(frameDone), 64'(tbl[i].done));
      chk($sformatf("%s[%0d].frameErr", tag, i), 64'(frameErr), 64'(tbl[i].err));
      chk($sformatf("%s[%0d].done4", tag, i), 64'(done4), 64'(tbl[i].done));
    end
    tbl.delete();
    dinValid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst.hitValid", 64'(hitValid), 64'd0);
    chk("rst.hitRecord", 64'(hitRecord), 64'd0);
    chk("rst.frameDone", 64'(frameDone), 64'd0);
    chk("rst.frameErr", 64'(frameErr), 64'd0);
    chk("rst.frameL1C", 64'(frameL1C), 64'd0);
    chk("rst.frameBCID", 64'(frameBCID), 64'd0);
    chk("rst.frameCnt", 64'(frameCnt), 64'd0);
    chk("rst.hitCnt", 64'(hitCnt), 64'd0);
    chk("rst.errCnt", 64'(errCnt), 64'd0);
    #5;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    last_rec = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Unfiltered 3-hit frame
    add(1, hdr(8'h12, 12'h345), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h21, 10'h011), 0, 8'h00, 1, 0, 0);
    add(1, dw(8'h21, 10'h022), 0, 8'h00, 1, 0, 0);
    add(0, dw(8'h21, 10'h0AA), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h37, 10'h033), 0, 8'h00, 1, 0, 0);
    add(1, trl(8'd3), 0, 8'h00, 0, 1, 0);
    run_table("A");
    chk("A.frameL1C", 64'(frameL1C), 64'h12);
    chk("A.frameBCID", 64'(frameBCID), 64'h345);
    chk("A.frameCnt", 64'(frameCnt), 64'd1);
    chk("A.hitCnt", 64'(hitCnt), 64'd3);
    chk("A.errCnt", 64'(errCnt), 64'd0);

    // Pixel filter on 8'h21
    do_reset();
    add(1, hdr(8'h12, 12'h345), 1, 8'h21, 0, 0, 0);
    add(1, dw(8'h21, 10'h011), 1, 8'h21, 1, 0, 0);
    add(1, dw(8'h21, 10'h022), 1, 8'h21, 1, 0, 0);
    add(1, dw(8'h37, 10'h033), 1, 8'h21, 0, 0, 0);
    add(1, trl(8'd3), 1, 8'h21, 0, 1, 0);
    run_table("B");
    chk("B.hitRec.pix", 64'(hitRecord[36:29]), 64'h21);
    chk("B.frameCnt", 64'(frameCnt), 64'd1);
    chk("B.hitCnt", 64'(hitCnt), 64'd2);

    // Trailer count mismatch
    do_reset();
    add(1, hdr(8'h55, 12'h0AB), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h10, 10'h101), 0, 8'h00, 1, 0, 0);
    add(1, dw(8'h11, 10'h102), 0, 8'h00, 1, 0, 0);
    add(1, trl(8'd5), 0, 8'h00, 0, 0, 1);
    run_table("C");
    chk("C.errCnt", 64'(errCnt), 64'd1);
    chk("C.frameCnt", 64'(frameCnt), 64'd0);
    chk("C.hitCnt", 64'(hitCnt), 64'd2);
    chk("C.frameL1C", 64'(frameL1C), 64'd0);

    // Orphan data, duplicate header, then a good frame
    do_reset();
    add(1, dw(8'h44, 10'h201), 0, 8'h00, 0, 0, 1);
    add(1, hdr(8'h01, 12'h001), 0, 8'h00, 0, 0, 0);
    add(1, hdr(8'h02, 12'h002), 0, 8'h00, 0, 0, 1);
    add(1, dw(8'h45, 10'h202), 0, 8'h00, 1, 0, 0);
    add(1, trl(8'd1), 0, 8'h00, 0, 1, 0);
    run_table("D");
    chk("D.errCnt", 64'(errCnt), 64'd2);
    chk("D.frameCnt", 64'(frameCnt), 64'd1);
    chk("D.frameL1C", 64'(frameL1C), 64'h02);
    chk("D.frameBCID", 64'(frameBCID), 64'h002);

    // Illegal word mid-frame, orphan trailer, 256-hit saturation
    do_reset();
    add(1, hdr(8'h07, 12'h777), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h12, 10'h301), 0, 8'h00, 1, 0, 0);
    add(1, {2'b00, 16'h1234, 22'h0}, 0, 8'h00, 0, 0, 1);
    add(1, trl(8'd1), 0, 8'h00, 0, 1, 0);
    add(1, trl(8'd0), 0, 8'h00, 0, 0, 1);
    add(1, hdr(8'h08, 12'h888), 0, 8'h00, 0, 0, 0);
    for (int unsigned i = 0; i < 256; i++)
      add(1, dw(8'(i), 10'(i)), 0, 8'h00, 1, 0, 0);
    add(1, trl(8'd0), 0, 8'h00, 0, 0, 1);
    run_table("E");
    chk("E.errCnt", 64'(errCnt), 64'd3);
    chk("E.frameCnt", 64'(frameCnt), 64'd1);
    chk("E.hitCnt", 64'(hitCnt), 64'd257);
    chk("E.frameL1C", 64'(frameL1C), 64'h07);

    // Reset mid-frame discards it; header afterwards decodes from IDLE
    add(1, hdr(8'h33, 12'h333), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h66, 10'h066), 0, 8'h00, 1, 0, 0);
    run_table("F0");
    do_reset();
    add(1, hdr(8'h34, 12'h334), 0, 8'h00, 0, 0, 0);
    add(1, dw(8'h67, 10'h067), 0, 8'h00, 1, 0, 0);
    add(1, trl(8'd1), 0, 8'h00, 0, 1, 0);
    run_table("F1");
    chk("F.frameCnt", 64'(frameCnt), 64'd1);
    chk("F.hitCnt", 64'(hitCnt), 64'd1);
    chk("F.errCnt", 64'(errCnt), 64'd0);
    chk("F.frameL1C", 64'(frameL1C), 64'h34);

    // 20 empty frames: 4-bit counter saturates at 15
    do_reset();
    for (int unsigned i = 0; i < 20; i++) begin
      add(1, hdr(8'(i), 12'(i)), 0, 8'h00, 0, 0, 0);
      add(1, trl(8'd0), 0, 8'h00, 0, 1, 0);
    end
    run_table("G");
    chk("G.frameCnt16", 64'(frameCnt), 64'd20);
    chk("G.frameCnt4", 64'(fcnt4), 64'd15);
    chk("G.errCnt4", 64'(ecnt4), 64'd0);
    chk("G.frameL1C", 64'(frameL1C), 64'd19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
